// File: rtl/mem_lsu_pipelined_if.sv
// mem_lsu_pipelined_if: core request, AXI4 master and CDB signals of the load/store unit
//   master: the LSU side (accepts requests, drives AXI AW/W/AR and ready for B/R, drives CDB)
//   slave : the core/memory side
interface mem_lsu_pipelined_if #(
    parameter int DATA_W   = 32,
    parameter int N_BANK   = 4,
    parameter int ADDR_W   = 28,
    parameter int RSV_ID_W = 5
);
    localparam int AXI_W  = DATA_W * N_BANK;
    localparam int STRB_W = AXI_W / 8;
    logic                       req_valid;
    logic                       req_ready;
    logic [RSV_ID_W-1:0]        req_rsv_id;
    logic                       req_store;
    logic                       req_byte;
    logic [ADDR_W-1:0]          req_addr;
    logic [DATA_W-1:0]          req_data;
    logic [ADDR_W-1:0]          m_awaddr;
    logic [7:0]                 m_awlen;
    logic [2:0]                 m_awsize;
    logic [1:0]                 m_awburst;
    logic                       m_awvalid;
    logic                       m_awready;
    logic [AXI_W-1:0]           m_wdata;
    logic [STRB_W-1:0]          m_wstrb;
    logic                       m_wlast;
    logic                       m_wvalid;
    logic                       m_wready;
    logic [1:0]                 m_bresp;
    logic                       m_bvalid;
    logic                       m_bready;
    logic [ADDR_W-1:0]          m_araddr;
    logic [7:0]                 m_arlen;
    logic [2:0]                 m_arsize;
    logic [1:0]                 m_arburst;
    logic                       m_arvalid;
    logic                       m_arready;
    logic [AXI_W-1:0]           m_rdata;
    logic [1:0]                 m_rresp;
    logic                       m_rvalid;
    logic                       m_rready;
    logic [RSV_ID_W+DATA_W-1:0] o_cdb;
    logic                       o_cdb_valid;
    logic                       o_cdb_ready;
    modport master (
        input  req_valid, req_rsv_id, req_store, req_byte, req_addr, req_data,
        output req_ready,
        output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid, input m_wready,
        input  m_bresp, m_bvalid, output m_bready,
        output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, input m_arready,
        input  m_rdata, m_rresp, m_rvalid, output m_rready,
        output o_cdb, o_cdb_valid, input o_cdb_ready
    );
    modport slave (
        output req_valid, req_rsv_id, req_store, req_byte, req_addr, req_data,
        input  req_ready,
        input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid, output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready,
        input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready,
        input  o_cdb, o_cdb_valid, output o_cdb_ready
    );
endinterface

// File: rtl/mem_lsu_pipelined.sv
// mem_lsu_pipelined: pipelined load/store unit, in-order load results on the CDB, stores ordered against loads
//   clk, rst   : clock, synchronous active-high reset
//   bus        : request, AXI4 master and CDB signals (master modport)
//   err_sticky : set by any nonzero B/R response, cleared only by rst
module mem_lsu_pipelined #(
    parameter int DATA_W          = 32,
    parameter int N_BANK          = 4,
    parameter int ADDR_W          = 28,
    parameter int RSV_ID_W        = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_lsu_pipelined_if.master bus,
    output logic                err_sticky
);
    localparam int AXI_W  = DATA_W * N_BANK;
    localparam int STRB_W = AXI_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int LANE_W = OFF_W - 2;
    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TRK_W  = RSV_ID_W + 1 + OFF_W;
    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
    state_t              state, state_nxt;
    logic [CNT_W-1:0]    inflight;
    logic [PTR_W-1:0]    wp, rp;
    logic [TRK_W-1:0]    trk [MAX_OUTSTANDING];
    logic [RSV_ID_W-1:0] hd_id;
    logic                hd_byte;
    logic [OFF_W-1:0]    hd_off;
    logic [LANE_W-1:0]   hd_lane;
    logic [DATA_W-1:0]   result;
    logic [OFF_W-1:0]    req_off;
    logic [LANE_W-1:0]   req_lane;
    logic                trk_ne, ld_ok, st_ok, ld_acc, st_acc, pop, wr_done;
    assign req_off  = bus.req_addr[OFF_W-1:0];
    assign req_lane = req_off[OFF_W-1:2];
    assign trk_ne   = inflight != '0;
    assign ld_ok    = state == IDLE && (!bus.m_arvalid || bus.m_arready) && inflight < CNT_W'(MAX_OUTSTANDING);
    assign st_ok    = state == IDLE && !trk_ne && !bus.m_arvalid;
    assign bus.req_ready = !rst && (bus.req_store ? st_ok : ld_ok);
    assign ld_acc   = bus.req_valid && bus.req_ready && !bus.req_store;
    assign st_acc   = bus.req_valid && bus.req_ready && bus.req_store;
    // R beats are only presented/acknowledged while a load is tracked, so stale responses after reset are ignored
    assign bus.o_cdb_valid = bus.m_rvalid && trk_ne;
    assign bus.m_rready    = bus.o_cdb_ready && trk_ne;
    assign pop             = bus.m_rvalid && bus.m_rready;
    assign {hd_id, hd_byte, hd_off} = trk[rp];
    assign hd_lane = hd_off[OFF_W-1:2];
    assign result  = hd_byte ? DATA_W'(bus.m_rdata[8*hd_off +: 8]) : bus.m_rdata[DATA_W*hd_lane +: DATA_W];
    assign bus.o_cdb     = {hd_id, result};
    assign bus.m_awlen   = 8'd0;
    assign bus.m_awsize  = 3'(OFF_W);
    assign bus.m_awburst = 2'b01;
    assign bus.m_arlen   = 8'd0;
    assign bus.m_arsize  = 3'(OFF_W);
    assign bus.m_arburst = 2'b01;
    assign bus.m_wlast   = bus.m_wvalid;
    // AW and W complete independently; leave WRITE once neither is still pending after this edge
    assign wr_done = (!bus.m_awvalid || bus.m_awready) && (!bus.m_wvalid || bus.m_wready);
    always_comb begin
        state_nxt    = state;
        bus.m_bready = 1'b0;
        unique case (state)
            IDLE:    state_nxt = st_acc ? WRITE : IDLE;
            WRITE:   state_nxt = wr_done ? RESP : WRITE;
            RESP: begin
                bus.m_bready = 1'b1;
                state_nxt    = bus.m_bvalid ? IDLE : RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (ld_acc) trk[wp] <= {bus.req_rsv_id, bus.req_byte, req_off};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            inflight      <= '0;
            wp            <= '0;
            rp            <= '0;
            bus.m_arvalid <= 1'b0;
            bus.m_araddr  <= '0;
            bus.m_awvalid <= 1'b0;
            bus.m_awaddr  <= '0;
            bus.m_wvalid  <= 1'b0;
            bus.m_wdata   <= '0;
            bus.m_wstrb   <= '0;
            err_sticky    <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= inflight + CNT_W'(ld_acc) - CNT_W'(pop);
            if (ld_acc) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (ld_acc) begin
                bus.m_arvalid <= 1'b1;
                bus.m_araddr  <= bus.req_addr;
            end else if (bus.m_arready) begin
                bus.m_arvalid <= 1'b0;
            end
            if (st_acc) begin
                bus.m_awvalid <= 1'b1;
                bus.m_wvalid  <= 1'b1;
                bus.m_awaddr  <= bus.req_addr;
                bus.m_wdata   <= bus.req_byte ? {STRB_W{bus.req_data[7:0]}} : {N_BANK{bus.req_data}};
                bus.m_wstrb   <= bus.req_byte ? STRB_W'(1) << req_off
                                              : STRB_W'({(DATA_W/8){1'b1}}) << (req_lane * (DATA_W/8));
            end else begin
                if (bus.m_awready) bus.m_awvalid <= 1'b0;
                if (bus.m_wready) bus.m_wvalid <= 1'b0;
            end
            if ((pop && bus.m_rresp != 2'b00) || (bus.m_bvalid && bus.m_bready && bus.m_bresp != 2'b00))
                err_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_lsu_pipelined.sv
// tb_mem_lsu_pipelined: directed self-checking bench for mem_lsu_pipelined
module tb_mem_lsu_pipelined;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
    int   checks = 0;
    int   failures = 0;
    mem_lsu_pipelined_if bus ();
    mem_lsu_pipelined dut (.clk(clk), .rst(rst), .bus(bus.master), .err_sticky(err));
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic st, input logic by, input logic [27:0] a, input logic [31:0] d, input logic [4:0] id);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_byte   = by;
        bus.req_addr   = a;
        bus.req_data   = d;
        bus.req_rsv_id = id;
    endtask
    task automatic issue(input logic st, input logic by, input logic [27:0] a, input logic [31:0] d, input logic [4:0] id);
        drive(st, by, a, d, id);
        #1;
        chk("req_ready_on_issue", bus.req_ready, 1);
        tick;
        bus.req_valid = 1'b0;
    endtask
    task automatic rbeat(input logic [127:0] d, input logic [1:0] resp, input logic [4:0] id, input logic [31:0] v);
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = d;
        bus.m_rresp  = resp;
        #1;
        chk("cdb_valid", bus.o_cdb_valid, 1);
        chk("cdb", bus.o_cdb, {id, v});
        chk("rready", bus.m_rready, 1);
        tick;
        bus.m_rvalid = 1'b0;
        bus.m_rresp  = 2'b00;
    endtask
    initial begin
        drive(0, 0, 0, 0, 0);
        bus.req_valid   = 1'b0;
        bus.m_awready   = 1'b0;
        bus.m_wready    = 1'b0;
        bus.m_bresp     = 2'b00;
        bus.m_bvalid    = 1'b0;
        bus.m_arready   = 1'b0;
        bus.m_rdata     = '0;
        bus.m_rresp     = 2'b00;
        bus.m_rvalid    = 1'b0;
        bus.o_cdb_ready = 1'b1;
        tick;
        tick;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_arvalid", bus.m_arvalid, 0);
        chk("rst_awvalid", bus.m_awvalid, 0);
        chk("rst_wvalid", bus.m_wvalid, 0);
        chk("rst_bready", bus.m_bready, 0);
        chk("rst_rready", bus.m_rready, 0);
        chk("rst_cdb_valid", bus.o_cdb_valid, 0);
        chk("rst_err", err, 0);
        chk("awsize", bus.m_awsize, 4);
        chk("awlen_burst", {bus.m_awlen, bus.m_awburst}, 10'b0000000001);
        chk("arsize_len_burst", {bus.m_arsize, bus.m_arlen, bus.m_arburst}, {3'd4, 8'd0, 2'b01});
        rst = 1'b0;
        // word load, lane 1
        bus.m_arready = 1'b1;
        #1;
        chk("t1_arvalid_pre", bus.m_arvalid, 0);
        issue(0, 0, 28'h104, 0, 5'd3);
        chk("t1_arvalid", bus.m_arvalid, 1);
        chk("t1_araddr", bus.m_araddr, 28'h104);
        tick;
        chk("t1_arvalid_drop", bus.m_arvalid, 0);
        rbeat({32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111}, 0, 5'd3, 32'hDEADBEEF);
        chk("t1_cdb_idle", bus.o_cdb_valid, 0);
        // byte load, byte 11
        issue(0, 1, 28'h10B, 0, 5'd7);
        tick;
        rbeat({32'hFFFFFFFF, 32'hA5665544, 32'h0, 32'h0}, 0, 5'd7, 32'h000000A5);
        // byte store 0x3C to 0x207
        issue(1, 1, 28'h207, 32'h0000003C, 5'd1);
        chk("t2_awvalid", bus.m_awvalid, 1);
        chk("t2_wvalid", bus.m_wvalid, 1);
        chk("t2_wlast", bus.m_wlast, 1);
        chk("t2_awaddr", bus.m_awaddr, 28'h207);
        chk("t2_wstrb", bus.m_wstrb, 16'h0080);
        chk("t2_wdata", bus.m_wdata, {16{8'h3C}});
        bus.req_store = 1'b0;
        #1;
        chk("t2_no_load_in_write", bus.req_ready, 0);
        bus.m_awready = 1'b1;
        tick;
        bus.m_awready = 1'b0;
        chk("t2_aw_done", bus.m_awvalid, 0);
        chk("t2_w_pending", bus.m_wvalid, 1);
        chk("t2_bready_write", bus.m_bready, 0);
        bus.m_wready = 1'b1;
        tick;
        bus.m_wready = 1'b0;
        chk("t2_w_done", bus.m_wvalid, 0);
        chk("t2_bready_resp", bus.m_bready, 1);
        bus.m_bvalid = 1'b1;
        tick;
        bus.m_bvalid = 1'b0;
        #1;
        chk("t2_bready_idle", bus.m_bready, 0);
        chk("t2_ready_idle", bus.req_ready, 1);
        // five loads, no R beats: fifth stalls until the first result pops
        for (int i = 0; i < 4; i++) begin
            issue(0, 0, 28'(i * 16), 0, 5'(10 + i));
            chk("t3_arvalid", bus.m_arvalid, 1);
            chk("t3_araddr", bus.m_araddr, 28'(i * 16));
        end
        drive(0, 0, 28'h040, 0, 5'd14);
        #1;
        chk("t3_fifth_stall", bus.req_ready, 0);
        tick;
        chk("t3_ar4_done", bus.m_arvalid, 0);
        chk("t3_still_full", bus.req_ready, 0);
        rbeat({96'h0, 32'h0000100A}, 0, 5'd10, 32'h0000100A);
        chk("t3_slot_free", bus.req_ready, 1);
        tick;
        bus.req_valid = 1'b0;
        chk("t3_fifth_ar", bus.m_arvalid, 1);
        chk("t3_fifth_addr", bus.m_araddr, 28'h040);
        tick;
        for (int i = 11; i < 15; i++) rbeat({96'h0, 32'(32'h1000 + i)}, 0, 5'(i), 32'(32'h1000 + i));
        // store behind two loads, then a load behind the store
        issue(0, 0, 28'h304, 0, 5'd20);
        issue(0, 0, 28'h308, 0, 5'd21);
        drive(1, 0, 28'h30C, 32'hCAFEF00D, 5'd2);
        #1;
        chk("t4_store_blocked", bus.req_ready, 0);
        tick;
        chk("t4_store_blocked2", bus.req_ready, 0);
        rbeat({32'h0, 32'h21210002, 32'h20200001, 32'h0}, 0, 5'd20, 32'h20200001);
        chk("t4_store_blocked3", bus.req_ready, 0);
        rbeat({32'h0, 32'h21210002, 32'h20200001, 32'h0}, 0, 5'd21, 32'h21210002);
        chk("t4_store_ready", bus.req_ready, 1);
        tick;
        bus.req_valid = 1'b0;
        chk("t4_awvalid", bus.m_awvalid, 1);
        chk("t4_wvalid", bus.m_wvalid, 1);
        chk("t4_awaddr", bus.m_awaddr, 28'h30C);
        chk("t4_wstrb", bus.m_wstrb, 16'hF000);
        chk("t4_wdata", bus.m_wdata, {4{32'hCAFEF00D}});
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        tick;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        chk("t4_both_done", {bus.m_awvalid, bus.m_wvalid, bus.m_bready}, 3'b001);
        drive(0, 1, 28'h001, 0, 5'd22);
        #1;
        chk("t4_load_wait_b", bus.req_ready, 0);
        tick;
        chk("t4_load_wait_b2", bus.req_ready, 0);
        bus.m_bvalid = 1'b1;
        #1;
        chk("t4_load_wait_b3", bus.req_ready, 0);
        tick;
        bus.m_bvalid = 1'b0;
        #1;
        chk("t4_load_ready", bus.req_ready, 1);
        tick;
        bus.req_valid = 1'b0;
        chk("t4_load_ar", bus.m_arvalid, 1);
        chk("t4_load_addr", bus.m_araddr, 28'h001);
        tick;
        rbeat({{7{16'hFFFF}}, 16'hC3FF}, 0, 5'd22, 32'h000000C3);
        // CDB back-pressure
        issue(0, 0, 28'h000, 0, 5'd5);
        issue(0, 0, 28'h004, 0, 5'd6);
        tick;
        bus.o_cdb_ready = 1'b0;
        bus.m_rvalid    = 1'b1;
        bus.m_rdata     = {32'h0, 32'h0, 32'h66, 32'h55};
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("t5_hold_valid", bus.o_cdb_valid, 1);
            chk("t5_hold_rready", bus.m_rready, 0);
            chk("t5_hold_cdb", bus.o_cdb, {5'd5, 32'h55});
            tick;
        end
        bus.o_cdb_ready = 1'b1;
        #1;
        chk("t5_rel_cdb0", bus.o_cdb, {5'd5, 32'h55});
        chk("t5_rel_rready", bus.m_rready, 1);
        tick;
        chk("t5_rel_cdb1", bus.o_cdb, {5'd6, 32'h66});
        tick;
        bus.m_rvalid = 1'b0;
        #1;
        chk("t5_drained", bus.o_cdb_valid, 0);
        // error response, then reset mid-store and mid-load
        issue(0, 0, 28'h008, 0, 5'd9);
        tick;
        chk("t6_err_before", err, 0);
        rbeat({32'h0, 32'h99, 64'h0}, 2'd2, 5'd9, 32'h99);
        chk("t6_err_set", err, 1);
        issue(1, 1, 28'h000, 32'h11, 5'd1);
        chk("t6_awvalid", bus.m_awvalid, 1);
        tick;
        chk("t6_aw_held", bus.m_awvalid, 1);
        chk("t6_err_held", err, 1);
        rst = 1'b1;
        tick;
        chk("t6_rst_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready}, 4'b0000);
        chk("t6_rst_err", err, 0);
        rst = 1'b0;
        bus.m_arready = 1'b0;
        issue(0, 0, 28'h000, 0, 5'd4);
        tick;
        chk("t6_ar_held", bus.m_arvalid, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_ar_flushed", bus.m_arvalid, 0);
        bus.m_rvalid = 1'b1;
        #1;
        chk("t6_stale_rready", bus.m_rready, 0);
        chk("t6_stale_cdb", bus.o_cdb_valid, 0);
        tick;
        bus.m_rvalid = 1'b0;
        chk("t6_err_clear", err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
